// File: rtl/gigatron_input_arbiter_if.sv
// Signal bundle between the Gigatron input pins/PS/2 decoder and the input arbiter.
// The master drives the raw pins and key codes; the slave (arbiter) returns the merged byte.
interface gigatron_input_arbiter_if;
    logic       HSYNC;
    logic       VSYNC;
    logic       SER_DATA;
    logic       KB_VALID;
    logic [7:0] KB_CODE;
    logic [7:0] IN_DATA;
    logic [1:0] IN_SRC;
    logic       SCAN_DONE;

    modport master (
        output HSYNC, VSYNC, SER_DATA, KB_VALID, KB_CODE,
        input  IN_DATA, IN_SRC, SCAN_DONE
    );

    modport slave (
        input  HSYNC, VSYNC, SER_DATA, KB_VALID, KB_CODE,
        output IN_DATA, IN_SRC, SCAN_DONE
    );
endinterface

// File: rtl/gigatron_input_arbiter.sv
// Gigatron input controller: scans the serial game pad once per frame from the sync
// strobes, holds PS/2 key codes for a few frames and presents one arbitrated active-low byte.
module gigatron_input_arbiter #(
    parameter int HOLD_FRAMES = 3,
    parameter int TIMER_W     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    gigatron_input_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_FRAMES);

    logic hsync_s1, hsync_s2, hsync_s3;
    logic vsync_s1, vsync_s2, vsync_s3;
    logic ser_s1, ser_s2;

    scan_state_t        state;
    logic [2:0]         bit_cnt;
    logic [7:0]         sh;
    logic [7:0]         pad_byte;
    logic [7:0]         kb_byte;
    logic [TIMER_W-1:0] kb_timer;

    logic [7:0] in_data_q;
    logic [1:0] in_src_q;
    logic       scan_done_q;

    logic h_rise;
    logic frame;
    logic [7:0] sh_next;

    // Synchronizers idle high so reset never fabricates an edge strobe
    always_ff @(posedge CLK) begin
        if (RST) begin
            hsync_s1 <= 1'b1;
            hsync_s2 <= 1'b1;
            hsync_s3 <= 1'b1;
            vsync_s1 <= 1'b1;
            vsync_s2 <= 1'b1;
            vsync_s3 <= 1'b1;
            ser_s1   <= 1'b1;
            ser_s2   <= 1'b1;
        end else begin
            hsync_s1 <= bus.HSYNC;
            hsync_s2 <= hsync_s1;
            hsync_s3 <= hsync_s2;
            vsync_s1 <= bus.VSYNC;
            vsync_s2 <= vsync_s1;
            vsync_s3 <= vsync_s2;
            ser_s1   <= bus.SER_DATA;
            ser_s2   <= ser_s1;
        end
    end

    assign h_rise  = hsync_s2 & ~hsync_s3;
    assign frame   = ~vsync_s2 & vsync_s3;
    assign sh_next = {sh[6:0], ser_s2};

    // The 8th bit is committed straight into pad_byte so it is visible during COMMIT,
    // the same cycle SCAN_DONE is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            sh          <= 8'hFF;
            pad_byte    <= 8'hFF;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame) begin
                        bit_cnt <= 3'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame) begin
                        bit_cnt <= 3'd0;
                    end else if (h_rise) begin
                        sh      <= sh_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            pad_byte    <= sh_next;
                            scan_done_q <= 1'b1;
                            state       <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    bit_cnt <= 3'd0;
                    state   <= frame ? SHIFT : IDLE;
                end
                default: begin
                    bit_cnt <= 3'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A fresh key load overrides a coincident frame decrement
    always_ff @(posedge CLK) begin
        if (RST) begin
            kb_byte  <= 8'hFF;
            kb_timer <= '0;
        end else if (bus.KB_VALID) begin
            kb_byte  <= bus.KB_CODE;
            kb_timer <= HOLD_LOAD;
        end else if (frame && (kb_timer != '0)) begin
            kb_timer <= kb_timer - TIMER_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_data_q <= 8'hFF;
            in_src_q  <= 2'b00;
        end else if (pad_byte != 8'hFF) begin
            in_data_q <= pad_byte;
            in_src_q  <= 2'b01;
        end else if (kb_timer != '0) begin
            in_data_q <= kb_byte;
            in_src_q  <= 2'b10;
        end else begin
            in_data_q <= 8'hFF;
            in_src_q  <= 2'b00;
        end
    end

    assign bus.IN_DATA   = in_data_q;
    assign bus.IN_SRC    = in_src_q;
    assign bus.SCAN_DONE = scan_done_q;

endmodule

// File: tb/tb_gigatron_input_arbiter.sv
// Bench for gigatron_input_arbiter: pad scans are scoreboarded against SCAN_DONE,
// key hold, priority, reset and coincident-strobe cases are checked directly.
module tb_gigatron_input_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gigatron_input_arbiter_if bus();

    gigatron_input_arbiter #(
        .HOLD_FRAMES(3),
        .TIMER_W    (4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks       = 0;
    int   failures     = 0;
    int   done_cnt     = 0;
    int   exp_done     = 0;
    logic done_pending = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: one CLK after SCAN_DONE the arbitrated output must match the queued entry
    always @(negedge clk) begin
        if (done_pending) begin
            done_pending = 1'b0;
            if (sb.size() == 0) begin
                check_val("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("sb_in_data", 32'(bus.IN_DATA), 32'(mon_e.data));
                check_val("sb_in_src", 32'(bus.IN_SRC), 32'(mon_e.src));
            end
        end
        if (bus.SCAN_DONE === 1'b1) begin
            done_cnt++;
            done_pending = 1'b1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic h_pulse(input logic b);
        bus.SER_DATA = b;
        bus.HSYNC    = 1'b1;
        tick(4);
        bus.HSYNC    = 1'b0;
        tick(4);
    endtask

    task automatic frame_pulse();
        bus.VSYNC = 1'b0;
        tick(4);
        bus.VSYNC = 1'b1;
        tick(4);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        sb.push_back(e);
        exp_done++;
    endtask

    task automatic shift_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) h_pulse(d[i]);
    endtask

    task automatic scan(input logic [7:0] d, input logic [7:0] exp_d, input logic [1:0] exp_s);
        frame_pulse();
        push_exp(exp_d, exp_s);
        shift_byte(d);
        check_val("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic key_pulse(input logic [7:0] code);
        bus.KB_CODE  = code;
        bus.KB_VALID = 1'b1;
        tick(1);
        bus.KB_VALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        bus.HSYNC    = 1'b0;
        bus.VSYNC    = 1'b1;
        bus.SER_DATA = 1'b1;
        bus.KB_VALID = 1'b0;
        bus.KB_CODE  = 8'h00;
        tick(3);
        check_val("rst_in_data", 32'(bus.IN_DATA), 32'hFF);
        check_val("rst_in_src", 32'(bus.IN_SRC), 32'd0);
        check_val("rst_scan_done", 32'(bus.SCAN_DONE), 32'd0);
        rst = 1'b0;
        tick(4);
        check_val("idle_in_data", 32'(bus.IN_DATA), 32'hFF);
        check_val("idle_state", 32'(dut.state), 32'd0);

        // Reset in the middle of a scan with four bits in
        frame_pulse();
        for (int i = 0; i < 4; i++) h_pulse(1'b0);
        check_val("mid_bit_cnt", 32'(dut.bit_cnt), 32'd4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_val("midrst_in_data", 32'(bus.IN_DATA), 32'hFF);
        check_val("midrst_in_src", 32'(bus.IN_SRC), 32'd0);
        check_val("midrst_scan_done", 32'(bus.SCAN_DONE), 32'd0);
        check_val("midrst_state", 32'(dut.state), 32'd0);
        check_val("midrst_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        tick(3);

        // Clean scan of 1,1,0,1,1,1,1,1 then release the pad
        scan(8'hDF, 8'hDF, 2'b01);
        scan(8'hFF, 8'hFF, 2'b00);

        // Aborted partial scan followed by a full 7F scan
        frame_pulse();
        for (int i = 0; i < 5; i++) h_pulse(1'b0);
        check_val("abort_no_done", 32'(done_cnt), 32'(exp_done));
        scan(8'h7F, 8'h7F, 2'b01);
        check_val("abort_pad_byte", 32'(dut.pad_byte), 32'h7F);
        scan(8'hFF, 8'hFF, 2'b00);

        // Key hold for three frames
        key_pulse(8'h61);
        check_val("key_lag", 32'(bus.IN_DATA), 32'hFF);
        tick(1);
        check_val("key_data", 32'(bus.IN_DATA), 32'h61);
        check_val("key_src", 32'(bus.IN_SRC), 32'd2);
        frame_pulse();
        check_val("key_f1_data", 32'(bus.IN_DATA), 32'h61);
        frame_pulse();
        check_val("key_f2_data", 32'(bus.IN_DATA), 32'h61);
        check_val("key_f2_src", 32'(bus.IN_SRC), 32'd2);
        bus.VSYNC = 1'b0;
        tick(3);
        check_val("key_f3_edge", 32'(bus.IN_DATA), 32'h61);
        tick(1);
        check_val("key_f3_data", 32'(bus.IN_DATA), 32'hFF);
        check_val("key_f3_src", 32'(bus.IN_SRC), 32'd0);
        bus.VSYNC = 1'b1;
        tick(4);

        // Pad priority over a held key, key returns when the pad releases
        key_pulse(8'h0A);
        tick(1);
        check_val("prio_key_data", 32'(bus.IN_DATA), 32'h0A);
        scan(8'hFE, 8'hFE, 2'b01);
        scan(8'hFF, 8'h0A, 2'b10);
        frame_pulse();
        check_val("prio_expire_data", 32'(bus.IN_DATA), 32'hFF);
        check_val("prio_expire_src", 32'(bus.IN_SRC), 32'd0);

        // KB_VALID coincident with a frame strobe reloads without decrement
        key_pulse(8'h55);
        frame_pulse();
        check_val("coinc_timer_pre", 32'(dut.kb_timer), 32'd2);
        bus.VSYNC = 1'b0;
        tick(2);
        key_pulse(8'h55);
        tick(1);
        check_val("coinc_timer", 32'(dut.kb_timer), 32'd3);
        check_val("coinc_key_data", 32'(bus.IN_DATA), 32'h55);
        bus.VSYNC = 1'b1;
        tick(4);

        // h_rise coincident with frame drops the bit and restarts the count
        frame_pulse();
        for (int i = 0; i < 3; i++) h_pulse(1'b0);
        check_val("hf_bit_cnt_pre", 32'(dut.bit_cnt), 32'd3);
        bus.SER_DATA = 1'b0;
        bus.VSYNC    = 1'b0;
        bus.HSYNC    = 1'b1;
        tick(4);
        check_val("hf_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        check_val("hf_state", 32'(dut.state), 32'd1);
        bus.VSYNC = 1'b1;
        bus.HSYNC = 1'b0;
        tick(4);
        push_exp(8'hA5, 2'b01);
        shift_byte(8'hA5);
        check_val("hf_drain", 32'(sb.size()), 32'd0);

        tick(4);
        check_val("done_total", 32'(done_cnt), 32'(exp_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gigatron_input_arbiter.md
# gigatron_input_arbiter

Input-side controller for the Gigatron peripheral block. It sequences the serial game-controller scan from the video sync strobes and shifts in one byte per frame. It merges that byte with key codes from a PS/2 decoder and presents one arbitrated, active-low input byte to the input-register/BUS driver. It runs on the system clock and samples HSYNC, VSYNC and SER_DATA asynchronously.

## Interface
- HOLD_FRAMES, 3: frames a key code remains presented after KB_VALID (1..2^TIMER_W-1)
- TIMER_W, 4: width of key-hold frame counter
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- HSYNC  in  1  horizontal sync, async; rising edge = one controller bit clock
- VSYNC  in  1  vertical sync, async, active low; falling edge = frame start
- SER_DATA  in  1  controller serial data, async
- KB_VALID  in  1  one-CLK pulse, KB_CODE valid
- KB_CODE  in  8  key byte from PS/2 decoder (ASCII or active-low button mask)
- IN_DATA  out  8  arbitrated input byte, registered
- IN_SRC  out  2  00 idle, 01 pad, 10 keyboard; registered
- SCAN_DONE  out  1  one-CLK pulse when a full pad byte commits

## Operation
- HSYNC, VSYNC, SER_DATA each pass through a 2-flop synchronizer (s1, s2) plus a third delay flop s3.
  - h_rise = HSYNC_s2 & ~HSYNC_s3.
  - frame = ~VSYNC_s2 & VSYNC_s3.
  - Serial data is sampled from SER_DATA_s2.
- Scan FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on frame, clear bit_cnt and go to SHIFT.
  - SHIFT: on h_rise, sh <= {sh[6:0], SER_DATA_s2} and bit_cnt++. When bit_cnt reaches 7 and h_rise occurs, go to COMMIT.
  - COMMIT: pad_byte <= sh, SCAN_DONE=1, then return to IDLE. Lasts exactly one cycle.
  - frame while in SHIFT: abort, clear bit_cnt, stay in SHIFT. pad_byte is unchanged.
  - frame while in COMMIT: the commit completes, and the next state is SHIFT with bit_cnt=0.
  - h_rise and frame in the same cycle: frame wins and the bit is discarded.
- Key hold:
  - KB_VALID loads kb_byte <= KB_CODE and kb_timer <= HOLD_FRAMES.
  - Otherwise, on frame with kb_timer != 0, kb_timer decrements.
  - KB_VALID and frame in the same cycle: load wins, with no decrement.
- Arbitration, registered each cycle:
  - pad_byte != 8'hFF (any button pressed): IN_DATA=pad_byte, IN_SRC=01.
  - else if kb_timer != 0: IN_DATA=kb_byte, IN_SRC=10.
  - else: IN_DATA=8'hFF, IN_SRC=00.
  - Pad has strict priority. The key timer keeps running while the pad is shown.
- Reset values:
  - state=IDLE, bit_cnt=0, sh=8'hFF, pad_byte=8'hFF, kb_byte=8'hFF, kb_timer=0.
  - IN_DATA=8'hFF, IN_SRC=00, SCAN_DONE=0.
  - All synchronizer flops are 1.
- Reset mid-scan discards partial bits. RST dominates every other input.

## Timing
- Pin edge to internal edge strobe: 3 CLK (two synchronizer stages plus the edge flop).
- 8th h_rise to SCAN_DONE: 1 CLK (the COMMIT cycle). pad_byte becomes visible in the same cycle as SCAN_DONE.
- IN_DATA/IN_SRC lag: 1 CLK after a pad_byte, kb_byte or kb_timer change.
- KB_VALID at cycle n gives IN_DATA=KB_CODE at n+2 if the pad is idle.
- A key is presented for exactly HOLD_FRAMES frame strobes: it is cleared 1 CLK after the HOLD_FRAMES-th frame following the load.
- Assumed input minimums: HSYNC high and low each ≥3 CLK. VSYNC pulses ≥3 CLK. Shorter pulses may be missed and need not be handled.
- bit_cnt is 3 bits. It is never observed past 7 because COMMIT exits SHIFT.

## Test plan
- Reset: assert RST 2 cycles mid-SHIFT with 4 bits in. Required: IN_DATA=FF, IN_SRC=00, SCAN_DONE=0, state IDLE, and the next full scan starts clean.
- Pad scan: frame, then serial bits 1,1,0,1,1,1,1,1 on 8 HSYNC rises. Required: SCAN_DONE pulse once, IN_DATA=8'hDF, IN_SRC=01, 1 CLK after SCAN_DONE.
- Abort: frame, 5 bits, frame, 8 bits of 8'h7F. Required: exactly one SCAN_DONE, pad_byte=7F, and no commit from the partial scan.
- Key hold with HOLD_FRAMES=3: pad idle, KB_VALID with 8'h61. Required:
  - IN_DATA=61, IN_SRC=10, 2 CLK later.
  - Value held through 2 frames.
  - IN_DATA=FF and IN_SRC=00 after the 3rd frame.
- Priority: key 8'h0A held, then pad scan commits 8'hFE. Required:
  - IN_DATA=FE, IN_SRC=01 while the pad is pressed.
  - Key returns if the pad goes back to FF before the timer expires.
- Simultaneous events:
  - KB_VALID coincident with frame: timer reloads to 3, with no decrement.
  - h_rise coincident with frame: bit dropped, bit_cnt=0.
